// File: rtl/rf_access_pkg.sv
// Shared definitions for the register-file access front-end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_access_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESP,
        ST_WRITE,
        ST_DUMP,
        ST_CLEAR
    } state_e;

endpackage

// File: rtl/rf_access_ctrl.sv
// Purpose: serialise READ/WRITE/DUMP/CLEAR commands onto register-file ports, return beats.
// Latency: READ resp T+1, WRITE resp T+2, DUMP first beat T+1, CLEAR resp T+NUM_REGS+1.
// Backpressure: one command in flight; resp_* held stable while resp_valid && !resp_ready.
//
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data command
// stream; resp_valid/resp_ready/resp_addr/resp_data/resp_last response stream;
// rf_ra/rf_rd register-file read port (combinational read); rf_wa/rf_wd/rf_we write port.
// Build option: define RF_ACCESS_X0_ZERO_EN to treat register 0 as hard-wired zero.
module rf_access_ctrl
    import rf_access_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_rd,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_we
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef RF_ACCESS_X0_ZERO_EN
    localparam bit X0_ZERO = 1'b1;
`else
    localparam bit X0_ZERO = 1'b0;
`endif

    // Register 0 reads as zero when the hard-wired-zero option is built in.
    function automatic logic [DATA_W-1:0] rd_mask(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] d);
        return (X0_ZERO && (a == '0)) ? '0 : d;
    endfunction

    state_e            state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_last_q, resp_last_d;
    logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic [ADDR_W-1:0] idx_next;
    logic              wr_allowed;

    assign idx_next   = idx_q + ADDR_W'(1);
    assign wr_allowed = !(X0_ZERO && (cmd_addr == '0));

    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_addr_d  = resp_addr_q;
        resp_data_d  = resp_data_q;
        resp_last_d  = resp_last_q;
        rf_wa_d      = rf_wa_q;
        rf_wd_d      = rf_wd_q;
        rf_we_d      = 1'b0;
        idx_d        = idx_q;
        rf_ra        = cmd_addr;

        case (state_q)
            ST_IDLE: begin
                // DUMP ignores cmd_addr; point the read port at register 0 so the
                // first beat can be captured on the accept edge.
                if (cmd_valid && (op_e'(cmd_op) == OP_DUMP)) begin
                    rf_ra = '0;
                end
                if (cmd_valid) begin
                    case (op_e'(cmd_op))
                        OP_READ: begin
                            resp_valid_d = 1'b1;
                            resp_addr_d  = cmd_addr;
                            resp_data_d  = rd_mask(cmd_addr, rf_rd);
                            resp_last_d  = 1'b1;
                            state_d      = ST_RESP;
                        end
                        OP_WRITE: begin
                            rf_wa_d = cmd_addr;
                            rf_wd_d = cmd_data;
                            rf_we_d = wr_allowed;
                            state_d = ST_WRITE;
                        end
                        OP_DUMP: begin
                            idx_d        = '0;
                            resp_valid_d = 1'b1;
                            resp_addr_d  = '0;
                            resp_data_d  = rd_mask('0, rf_rd);
                            resp_last_d  = (LAST_IDX == '0);
                            state_d      = ST_DUMP;
                        end
                        default: begin // OP_CLEAR
                            rf_we_d = 1'b1;
                            rf_wa_d = '0;
                            rf_wd_d = '0;
                            idx_d   = '0;
                            state_d = ST_CLEAR;
                        end
                    endcase
                end
            end

            ST_WRITE: begin
                rf_ra        = rf_wa_q;
                resp_valid_d = 1'b1;
                resp_addr_d  = rf_wa_q;
                // The register file only updates at the end of this cycle, so its
                // combinational read still shows the old value; forward the data
                // being written instead. A suppressed write reads back normally.
                resp_data_d  = rf_we_q ? rf_wd_q : rd_mask(rf_wa_q, rf_rd);
                resp_last_d  = 1'b1;
                state_d      = ST_RESP;
            end

            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end

            ST_DUMP: begin
                // Look one register ahead so the next beat loads on the handshake edge.
                rf_ra = idx_next;
                if (resp_ready) begin
                    if (resp_last_q) begin
                        resp_valid_d = 1'b0;
                        idx_d        = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        idx_d       = idx_next;
                        resp_addr_d = idx_next;
                        resp_data_d = rd_mask(idx_next, rf_rd);
                        resp_last_d = (idx_next == LAST_IDX);
                    end
                end
            end

            ST_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    idx_d        = '0;
                    resp_valid_d = 1'b1;
                    resp_addr_d  = LAST_IDX;
                    resp_data_d  = '0;
                    resp_last_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    idx_d   = idx_next;
                    rf_wa_d = idx_next;
                    rf_we_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
            rf_wa_q      <= '0;
            rf_wd_q      <= '0;
            rf_we_q      <= 1'b0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            resp_data_q  <= resp_data_d;
            resp_last_q  <= resp_last_d;
            rf_wa_q      <= rf_wa_d;
            rf_wd_q      <= rf_wd_d;
            rf_we_q      <= rf_we_d;
            idx_q        <= idx_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_addr  = resp_addr_q;
    assign resp_data  = resp_data_q;
    assign resp_last  = resp_last_q;
    assign rf_wa      = rf_wa_q;
    assign rf_wd      = rf_wd_q;
    assign rf_we      = rf_we_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural 32x32 register file behind it.
// Latency: n/a.
// Backpressure: resp_ready driven directly, including a toggling pattern.
module tb_rf_access_ctrl;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

`ifdef RF_ACCESS_X0_ZERO_EN
    localparam bit X0 = 1'b1;
`else
    localparam bit X0 = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [ADDR_W-1:0] resp_addr;
    logic [DATA_W-1:0] resp_data;
    logic              resp_last;
    logic [ADDR_W-1:0] rf_ra;
    logic [DATA_W-1:0] rf_rd;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic              rf_we;

    logic              preload;
    logic [DATA_W-1:0] mem [NREG];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_addr(resp_addr),
        .resp_data(resp_data), .resp_last(resp_last),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we)
    );

    function automatic logic [DATA_W-1:0] pat(input int i);
        return {16'hC0DE, 8'h00, 8'(i)};
    endfunction

    // Behavioural register file: synchronous write, combinational read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NREG; i++) mem[i] <= pat(i);
        end else if (rf_we) begin
            mem[rf_wa] <= rf_wd;
        end
    end
    assign rf_rd = mem[rf_ra];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers one command and returns one cycle after the accept edge.
    task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 5'd17;
        cmd_data  = 32'hFFFF_FFFF;
    endtask

    task automatic do_preload;
        preload = 1'b1;
        tick();
        preload = 1'b0;
    endtask

    initial begin
        int errs;
        int k;
        int cyc;
        logic [ADDR_W-1:0] p_addr;
        logic [DATA_W-1:0] p_data;
        logic              p_last;
        logic              p_stall;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_addr   = '0;
        cmd_data   = '0;
        resp_ready = 1'b0;
        preload    = 1'b0;

        // Reset state
        #1;
        check("ready_in_rst", 32'(cmd_ready), 32'd0);
        tick();
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_addr",  32'(resp_addr),  32'd0);
        check("rst_resp_data",  resp_data,       32'd0);
        check("rst_resp_last",  32'(resp_last),  32'd0);
        check("rst_rf_we",      32'(rf_we),      32'd0);
        check("rst_rf_wa",      32'(rf_wa),      32'd0);
        check("rst_rf_wd",      rf_wd,           32'd0);
        do_preload();
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // WRITE 5 <= DEADBEEF, response held under backpressure
        send(2'b01, 5'd5, 32'hDEAD_BEEF);
        check("wr_we_t1",    32'(rf_we),      32'd1);
        check("wr_wa_t1",    32'(rf_wa),      32'd5);
        check("wr_wd_t1",    rf_wd,           32'hDEAD_BEEF);
        check("wr_vld_t1",   32'(resp_valid), 32'd0);
        tick();
        check("wr_we_t2",    32'(rf_we),      32'd0);
        check("wr_vld_t2",   32'(resp_valid), 32'd1);
        check("wr_addr",     32'(resp_addr),  32'd5);
        check("wr_data",     resp_data,       32'hDEAD_BEEF);
        check("wr_last",     32'(resp_last),  32'd1);
        tick();
        check("wr_hold_vld", 32'(resp_valid), 32'd1);
        check("wr_hold_dat", resp_data,       32'hDEAD_BEEF);
        check("rf_mem5",     mem[5],          32'hDEAD_BEEF);
        resp_ready = 1'b1;
        tick();
        check("wr_done_vld", 32'(resp_valid), 32'd0);
        check("wr_done_rdy", 32'(cmd_ready),  32'd1);

        // READ 5 back, then READ 7 (preloaded)
        send(2'b00, 5'd5, 32'h0);
        check("rd5_vld",  32'(resp_valid), 32'd1);
        check("rd5_addr", 32'(resp_addr),  32'd5);
        check("rd5_data", resp_data,       32'hDEAD_BEEF);
        check("rd5_last", 32'(resp_last),  32'd1);
        tick();
        check("rd5_idle", 32'(cmd_ready),  32'd1);
        send(2'b00, 5'd7, 32'h0);
        check("rd7_data", resp_data,       pat(7));
        tick();

        // WRITE to register 0
        send(2'b01, 5'd0, 32'h1234_5678);
        check("wr0_we",   32'(rf_we),      X0 ? 32'd0 : 32'd1);
        tick();
        check("wr0_vld",  32'(resp_valid), 32'd1);
        check("wr0_data", resp_data,       X0 ? 32'h0 : 32'h1234_5678);
        tick();

        // CLEAR: 32 write cycles then one response beat
        send(2'b11, 5'd3, 32'hFFFF_FFFF);
        errs = 0;
        for (int i = 0; i < NREG; i++) begin
            if (rf_we !== 1'b1 || rf_wa !== 5'(i) || rf_wd !== 32'h0) errs++;
            if (resp_valid !== 1'b0) errs++;
            tick();
        end
        check("clr_write_seq", 32'(errs),      32'd0);
        check("clr_we_off",    32'(rf_we),     32'd0);
        check("clr_vld",       32'(resp_valid), 32'd1);
        check("clr_addr",      32'(resp_addr), 32'd31);
        check("clr_data",      resp_data,      32'd0);
        check("clr_last",      32'(resp_last), 32'd1);
        tick();
        check("clr_mem6",      mem[6],         32'd0);
        send(2'b00, 5'd6, 32'h0);
        check("rd6_data",      resp_data,      32'd0);
        tick();

        // DUMP after CLEAR with resp_ready held high
        send(2'b10, 5'd9, 32'h0);
        errs = 0;
        for (int i = 0; i < NREG; i++) begin
            if (resp_valid !== 1'b1 || resp_addr !== 5'(i) || resp_data !== 32'h0) errs++;
            if (resp_last !== (i == NREG - 1)) errs++;
            tick();
        end
        check("dump0_beats", 32'(errs),       32'd0);
        check("dump0_end",   32'(resp_valid), 32'd0);
        check("dump0_idle",  32'(cmd_ready),  32'd1);

        // DUMP of preloaded pattern with resp_ready toggling every cycle
        do_preload();
        resp_ready = 1'b0;
        send(2'b10, 5'd0, 32'h0);
        errs    = 0;
        k       = 0;
        cyc     = 0;
        p_stall = 1'b0;
        p_addr  = '0;
        p_data  = '0;
        p_last  = 1'b0;
        while (k < NREG && cyc < 200) begin
            if (resp_valid !== 1'b1) errs++;
            if (resp_addr !== 5'(k)) errs++;
            if (resp_data !== ((X0 && k == 0) ? 32'h0 : pat(k))) errs++;
            if (resp_last !== (k == NREG - 1)) errs++;
            if (p_stall && (resp_addr !== p_addr || resp_data !== p_data ||
                            resp_last !== p_last)) errs++;
            p_addr  = resp_addr;
            p_data  = resp_data;
            p_last  = resp_last;
            p_stall = !resp_ready;
            if (resp_ready) k++;
            tick();
            resp_ready = ~resp_ready;
            cyc++;
        end
        check("dumpt_count", 32'(k),          32'(NREG));
        check("dumpt_beats", 32'(errs),       32'd0);
        check("dumpt_end",   32'(resp_valid), 32'd0);
        resp_ready = 1'b1;

        // Reset in the middle of CLEAR: writes 0..8 land, the rest stay intact
        do_preload();
        send(2'b11, 5'd0, 32'h0);
        cyc = 0;
        while (!(rf_we === 1'b1 && rf_wa === 5'd8) && cyc < 40) begin
            tick();
            cyc++;
        end
        check("clr_rst_reach", 32'(rf_wa), 32'd8);
        rst = 1'b1;
        tick();
        check("mid_rst_we",    32'(rf_we),      32'd0);
        check("mid_rst_vld",   32'(resp_valid), 32'd0);
        check("mid_rst_rdy",   32'(cmd_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_idle",  32'(cmd_ready),  32'd1);
        errs = 0;
        for (int i = 0; i < NREG; i++) begin
            if (i <= 8 && mem[i] !== 32'h0) errs++;
            if (i > 8 && mem[i] !== pat(i)) errs++;
        end
        check("mid_rst_mem",   32'(errs), 32'd0);
        send(2'b00, 5'd9, 32'h0);
        check("mid_rst_rd9",   resp_data, pat(9));
        tick();
        send(2'b00, 5'd3, 32'h0);
        check("mid_rst_rd3",   resp_data, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
